// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the execute/fetch stages and the branch resolve unit.
//
// Handshake: a resolving branch is presented with RES_VALID=1 for one cycle.
// There is no ready signal; FLUSH=1 acts as the only back-pressure. While
// FLUSH is high, RES_VALID is ignored because the instruction is squashed.
// An accepted branch produces its result one cycle later.
interface branch_resolve_unit_if #(
  parameter int PC_WIDTH   = 10,
  parameter int STAT_WIDTH = 16
);
  logic [PC_WIDTH-1:0]   FETCH_PC;
  logic                  PRED_TAKEN;
  logic                  RES_VALID;
  logic [3:0]            RES_TYPE;
  logic [PC_WIDTH-1:0]   RES_PC;
  logic [PC_WIDTH-1:0]   RES_TARGET;
  logic                  RES_PREDICTED;
  logic                  C;
  logic                  Z;
  logic                  BRANCH_TAKEN;
  logic                  BRANCH_MISS;
  logic [PC_WIDTH-1:0]   REDIRECT_PC;
  logic                  FLUSH;
  logic [STAT_WIDTH-1:0] BRANCH_COUNT;
  logic [STAT_WIDTH-1:0] MISS_COUNT;
  // Debug view of the flush state machine: 1 while in FLUSHING.
  logic                  flushing;

  modport master (
    output FETCH_PC, RES_VALID, RES_TYPE, RES_PC, RES_TARGET, RES_PREDICTED, C, Z,
    input  PRED_TAKEN, BRANCH_TAKEN, BRANCH_MISS, REDIRECT_PC, FLUSH,
           BRANCH_COUNT, MISS_COUNT, flushing
  );

  modport slave (
    input  FETCH_PC, RES_VALID, RES_TYPE, RES_PC, RES_TARGET, RES_PREDICTED, C, Z,
    output PRED_TAKEN, BRANCH_TAKEN, BRANCH_MISS, REDIRECT_PC, FLUSH,
           BRANCH_COUNT, MISS_COUNT, flushing
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with a PC-indexed table of 2-bit
// saturating predictors, a registered miss/redirect pulse, a fixed-length
// flush sequence and saturating branch/miss statistics.
module branch_resolve_unit #(
  parameter int         PC_WIDTH     = 10,
  parameter int         IDX_BITS     = 4,
  parameter logic [1:0] CTR_INIT     = 2'b01,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         STAT_WIDTH   = 16
) (
  input logic                  CLK,
  input logic                  RST,
  branch_resolve_unit_if.slave bus
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int CW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, FLUSHING = 1'b1} flush_state_t;

  logic [1:0]            tbl_q [DEPTH];
  flush_state_t          state_q;
  logic [CW-1:0]         cnt_q;
  logic                  flush_q;
  logic                  taken_q;
  logic                  miss_q;
  logic [PC_WIDTH-1:0]   redirect_q;
  logic [STAT_WIDTH-1:0] bcnt_q;
  logic [STAT_WIDTH-1:0] mcnt_q;

  logic                  taken;
  logic                  is_cond;
  logic                  is_branch;
  logic                  accept;
  logic                  miss;
  logic [IDX_BITS-1:0]   res_idx;
  logic [IDX_BITS-1:0]   fetch_idx;

  assign accept    = bus.RES_VALID & ~flush_q;
  assign miss      = accept & (bus.RES_PREDICTED ^ taken);
  assign res_idx   = bus.RES_PC[IDX_BITS-1:0];
  assign fetch_idx = bus.FETCH_PC[IDX_BITS-1:0];

  // Decode the branch type into its taken outcome and class.
  always_comb begin
    taken     = 1'b0;
    is_cond   = 1'b0;
    is_branch = 1'b1;
    case (bus.RES_TYPE)
      4'h1:    begin taken = ~bus.C; is_cond = 1'b1; end
      4'h2:    begin taken =  bus.C; is_cond = 1'b1; end
      4'h3:    begin taken =  bus.Z; is_cond = 1'b1; end
      4'h5:    begin taken = ~bus.Z; is_cond = 1'b1; end
      4'h4, 4'h6, 4'h7, 4'h8, 4'h9: taken = 1'b1;
      default: is_branch = 1'b0;
    endcase
  end

  // Prediction read is the stored counter; no bypass from a same-cycle update.
  assign bus.PRED_TAKEN = tbl_q[fetch_idx][1];

  // Train the predictor table on accepted conditional branches only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_INIT;
    end else if (accept && is_cond) begin
      if (taken) begin
        if (tbl_q[res_idx] != 2'b11) tbl_q[res_idx] <= tbl_q[res_idx] + 2'b01;
      end else begin
        if (tbl_q[res_idx] != 2'b00) tbl_q[res_idx] <= tbl_q[res_idx] - 2'b01;
      end
    end
  end

  // Register the resolved outcome; REDIRECT_PC only moves on accepted branches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      taken_q    <= 1'b0;
      miss_q     <= 1'b0;
      redirect_q <= '0;
    end else begin
      taken_q <= accept & taken;
      miss_q  <= miss;
      if (accept) begin
        redirect_q <= taken ? bus.RES_TARGET : bus.RES_PC + PC_WIDTH'(1);
      end
    end
  end

  // Flush sequencer: FLUSH rises with the miss pulse and lasts FLUSH_CYCLES.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q <= FLUSHING;
            cnt_q   <= CW'(FLUSH_CYCLES - 1);
            flush_q <= 1'b1;
          end
        end
        FLUSHING: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics; type 0 misses count as misses but not branches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (accept && is_branch && (bcnt_q != {STAT_WIDTH{1'b1}})) begin
        bcnt_q <= bcnt_q + STAT_WIDTH'(1);
      end
      if (miss && (mcnt_q != {STAT_WIDTH{1'b1}})) begin
        mcnt_q <= mcnt_q + STAT_WIDTH'(1);
      end
    end
  end

  assign bus.BRANCH_TAKEN = taken_q;
  assign bus.BRANCH_MISS  = miss_q;
  assign bus.REDIRECT_PC  = redirect_q;
  assign bus.FLUSH        = flush_q;
  assign bus.BRANCH_COUNT = bcnt_q;
  assign bus.MISS_COUNT   = mcnt_q;
  assign bus.flushing     = (state_q == FLUSHING);

endmodule
